// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port to one-port cache-line memory arbiter. Port A
//               (instruction cache) and port B (data cache) share one
//               physical memory port. A single transaction is in flight
//               at a time. After each completion, one DONE cycle masks the
//               request that the served cache may still be holding.
//
//               Optional feature macro: ARB_ROUND_ROBIN_EN
//                 undefined : fixed priority, B wins a simultaneous request
//                 defined   : a last-served flag grants the port that was
//                             not served last (flag resets to B)
//
// Ports       : clk, rst_n                        clock, async active-low reset
//               mem_read_x / mem_write_x          line read / write-back request
//               mem_address_x / mem_wdata_x       line address / write data
//               mem_rdata_x / mem_resp_x          read data / completion pulse
//                                                 (x = a, b)
//               pmem_read / pmem_write            physical memory request
//               pmem_address / pmem_wdata         physical memory addr / data
//               pmem_rdata / pmem_resp            physical memory data / done
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              mem_read_a,
    input  logic              mem_write_a,
    input  logic [ADDR_W-1:0] mem_address_a,
    input  logic [LINE_W-1:0] mem_wdata_a,
    output logic [LINE_W-1:0] mem_rdata_a,
    output logic              mem_resp_a,

    input  logic              mem_read_b,
    input  logic              mem_write_b,
    input  logic [ADDR_W-1:0] mem_address_b,
    input  logic [LINE_W-1:0] mem_wdata_b,
    output logic [LINE_W-1:0] mem_rdata_b,
    output logic              mem_resp_b,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic                pmem_read_q;
    logic                pmem_write_q;
    logic [ADDR_W-1:0]   pmem_address_q;
    logic [LINE_W-1:0]   pmem_wdata_q;

    logic                req_a_w;
    logic                req_b_w;
    logic                grant_b_d;

    assign req_a_w = mem_read_a | mem_write_a;
    assign req_b_w = mem_read_b | mem_write_b;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = port B was served most recently; on a tie the other port wins.
    logic last_b_q;
    assign grant_b_d = req_b_w & (~req_a_w | ~last_b_q);
`else
    assign grant_b_d = req_b_w;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q       <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_a_w | req_b_w) begin
                        // Write wins when read and write are both high.
                        if (grant_b_d) begin
                            state_q        <= BUSY_B;
                            pmem_write_q   <= mem_write_b;
                            pmem_read_q    <= mem_read_b & ~mem_write_b;
                            pmem_address_q <= mem_address_b;
                            pmem_wdata_q   <= mem_wdata_b;
                        end else begin
                            state_q        <= BUSY_A;
                            pmem_write_q   <= mem_write_a;
                            pmem_read_q    <= mem_read_a & ~mem_write_a;
                            pmem_address_q <= mem_address_a;
                            pmem_wdata_q   <= mem_wdata_a;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_b_q <= grant_b_d;
`endif
                    end
                end
                BUSY_A, BUSY_B: begin
                    // Registered request is frozen until memory completes.
                    if (pmem_resp) begin
                        state_q      <= DONE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Completion is forwarded combinationally to the granted port only;
    // a response arriving in IDLE/DONE therefore reaches no port.
    assign mem_resp_a  = (state_q == BUSY_A) & pmem_resp;
    assign mem_resp_b  = (state_q == BUSY_B) & pmem_resp;
    assign mem_rdata_a = mem_resp_a ? pmem_rdata : '0;
    assign mem_rdata_b = mem_resp_b ? pmem_rdata : '0;

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter LINE_W, default 256, cache-line data width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 mem_read_a  input  1  line read request, port A (instruction cache).
REQ-006 mem_write_a  input  1  line write-back request, port A.
REQ-007 mem_address_a  input  ADDR_W  line address, port A.
REQ-008 mem_wdata_a  input  LINE_W  write-back data, port A.
REQ-009 mem_rdata_a  output  LINE_W  read data, port A.
REQ-010 mem_resp_a  output  1  completion pulse, port A.
REQ-011 mem_read_b, mem_write_b, mem_address_b, mem_wdata_b, mem_rdata_b, mem_resp_b SHALL mirror REQ-005..010 for port B (data cache).
REQ-012 pmem_read / pmem_write  output  1  physical memory read / write request.
REQ-013 pmem_address  output  ADDR_W  physical memory line address.
REQ-014 pmem_wdata  output  LINE_W  physical memory write data.
REQ-015 pmem_rdata  input  LINE_W  physical memory read data.
REQ-016 pmem_resp  input  1  physical memory completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, BUSY_A, BUSY_B, DONE.
REQ-018 A port is requesting when its read or write is high; read and write both high SHALL be treated as a write.
REQ-019 IDLE: a single requester SHALL be granted (to BUSY_A/BUSY_B) at the next edge; no request keeps IDLE.
REQ-020 IDLE with both ports requesting SHALL grant B (fixed priority) unless REQ-034 applies.
REQ-021 On grant, address, wdata and op of the winner SHALL be registered; pmem_read or pmem_write asserts the cycle after the request is first seen in IDLE.
REQ-022 In BUSY_x, pmem_read/pmem_write, pmem_address, pmem_wdata SHALL be held constant until pmem_resp.
REQ-023 In BUSY_x with pmem_resp=1, mem_resp_x SHALL be 1 that same cycle (combinational) and mem_rdata_x SHALL equal pmem_rdata; next state DONE.
REQ-024 mem_rdata_x SHALL be 0 whenever mem_resp_x is 0; mem_resp of the non-granted port SHALL stay 0.
REQ-025 DONE SHALL deassert pmem_read/pmem_write, grant nothing, and go to IDLE next cycle (masks stale request held by served cache).
REQ-026 pmem_resp in IDLE or DONE SHALL be ignored.
REQ-027 Request changes on the granted port during BUSY_x SHALL not alter the in-flight pmem transaction.
REQ-028 The losing port SHALL remain pending without loss; it is granted at the next IDLE if still requesting.
REQ-029 Minimum round trip: request at cycle t, pmem_resp at t+1+k, mem_resp at t+1+k, next grant at t+3+k.

Reset
REQ-030 rst_n low SHALL force state IDLE immediately, independent of clk.
REQ-031 Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_resp_a/b=0, mem_rdata_a/b=0.
REQ-032 Reset mid-transaction SHALL abandon the in-flight pmem request; no mem_resp is issued for it.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-034 Defined: a last-served flag (reset value = B) SHALL grant the port not served last on simultaneous requests; undefined: fixed B priority, no flag logic.

Verification
REQ-035 Single A read 0x0000_1000, pmem_resp after 3 cycles with rdata 0xAA..AA -> mem_resp_a one pulse, mem_rdata_a=0xAA..AA, mem_resp_b=0.
REQ-036 Simultaneous A read 0x100, B write 0x200 -> B served first (pmem_write, address 0x200), then A (pmem_read, address 0x100); with ARB_ROUND_ROBIN_EN, A first after reset.
REQ-037 B holds request one cycle after its mem_resp -> no second pmem transaction (DONE masks).
REQ-038 Change mem_address_b from 0x200 to 0x300 during BUSY_B -> pmem_address stays 0x200 until pmem_resp.
REQ-039 rst_n low two cycles into BUSY_A -> pmem_read=0 immediately, later pmem_resp yields no mem_resp_a.
REQ-040 Stray pmem_resp in IDLE -> no mem_resp on either port, state stays IDLE.
